// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with valid/ready handshakes on request and result sides.
// Optional iterative shift-add multiply on code 100 is enabled by defining ALU_MUL_EN.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;
`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam int         CNT_W  = $clog2(WIDTH);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ALU_MUL_EN
    ST_MUL  = 2'd2,
`endif
    ST_HOLD = 2'd1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             accept;
`ifdef ALU_MUL_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_sum;
`endif

  // Single-cycle operation; returns {illegal, result}. Code 100 lands here as illegal
  // only when the multiplier is not built.
  function automatic logic [WIDTH:0] single_op(input logic [2:0] code,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        r;
    logic                    bad;
    sa  = a;
    sb  = b;
    r   = '0;
    bad = 1'b0;
    case (code)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
      default: bad = 1'b1;
    endcase
    return {bad, r};
  endfunction

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready);
  assign out_valid = (state_q == ST_HOLD);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign accept    = in_valid & in_ready;

  always_comb begin
    logic [WIDTH:0] op_res;
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    op_res    = single_op(alu_ctrl, op_a, op_b);
`ifdef ALU_MUL_EN
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
`ifdef ALU_MUL_EN
      ST_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d  = acc_sum;
          zero_d    = (acc_sum == '0);
          illegal_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_HOLD;
        end
      end
`endif
      default: begin
        // IDLE and HOLD share the accept path; HOLD without a new accept drains to IDLE
        if ((state_q == ST_HOLD) && out_ready) state_d = ST_IDLE;
        if (accept) begin
`ifdef ALU_MUL_EN
          if (alu_ctrl == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = op_a;
            mplier_d = op_b;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else
`endif
          begin
            result_d  = op_res[WIDTH-1:0];
            illegal_d = op_res[WIDTH];
            zero_d    = (op_res[WIDTH-1:0] == '0);
            state_d   = ST_HOLD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

`ifdef ALU_MUL_EN
  // Partial-product datapath is only meaningful while in MUL, so it needs no reset
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes expected responses, monitor pops on handshake.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   alu_ctrl = 3'b000;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         il;
    int           due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   fresh = 1'b1;
  int   rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int c);
    exp_t        e;
    logic [63:0] p;
    e.r   = '0;
    e.il  = 1'b0;
    e.due = c + 1;
    p     = '0;
    case (op)
      3'd0: e.r = a + b;
      3'd1: e.r = a - b;
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd5: e.r = ($signed(a) < $signed(b)) ? 1 : 0;
`ifdef ALU_MUL_EN
      3'd4: begin
        p     = {32'b0, a} * {32'b0, b};
        e.r   = p[W-1:0];
        e.due = c + 1 + W;
      end
`endif
      default: e.il = 1'b1;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Monitor: every valid cycle is compared against the queue head
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        if (fresh) begin
          check("latency", cyc, q[0].due);
          fresh = 1'b0;
        end
        check("result", result, q[0].r);
        check("zero", zero, q[0].z);
        check("illegal", illegal, q[0].il);
        if (out_ready) begin
          void'(q.pop_front());
          fresh = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    alu_ctrl = op;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (!in_ready) begin
      check("issue_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    q.push_back(model(op, a, b, cyc));
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_illegal", illegal, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [2:0]   op;
    rdy_mode = 1;
    repeat (3) step();
    check_reset_state();
    rst_n = 1'b1;
    step();
    check_reset_state();

    // Wrap, SLT, bitwise, illegal codes and recovery
    issue(3'd0, 32'hFFFF_FFFF, 32'h1);
    issue(3'd1, 32'd5, 32'd7);
    issue(3'd5, 32'hFFFF_FFFF, 32'h1);
    issue(3'd5, 32'h1, 32'hFFFF_FFFF);
    issue(3'd2, 32'hF0F0, 32'h0FF0);
    issue(3'd3, 32'hF0F0, 32'h0FF0);
    issue(3'd6, 32'h1234, 32'h5678);
    issue(3'd7, 32'h1, 32'h1);
    issue(3'd0, 32'h2, 32'h3);
    drain();

    // Backpressure then back-to-back streaming
    rdy_mode = 0;
    step();
    issue(3'd0, 32'd3, 32'd4);
    repeat (4) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_result", result, 7);
      step();
    end
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) issue(3'd0, 32'(i * 100), 32'(i));
    drain();

    // Multiply (or illegal when not built)
    issue(3'd4, 32'd12, 32'd13);
`ifdef ALU_MUL_EN
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("mul_in_ready", in_ready, 0);
    end
`endif
    drain();
    issue(3'd4, 32'h1_0000, 32'h1_0000);
    drain();

    // Random traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (i % 7 == 0) a = 32'hFFFF_FFFF;
      if (i % 5 == 0) b = 32'h8000_0000;
      if (op == 3'd4 && (i % 2 == 0)) op = 3'd0;
      issue(op, a, b);
    end
    rdy_mode = 1;
    drain();

    // Reset in the middle of a long or stalled operation discards it
    rdy_mode = 0;
    step();
    issue(3'd4, 32'd7, 32'd9);
    repeat (4) step();
    rst_n = 1'b0;
    q.delete();
    fresh = 1'b1;
    step();
    check_reset_state();
    rst_n = 1'b1;
    rdy_mode = 1;
    step();
    check_reset_state();
    repeat (40) step();
    check("post_reset_quiet", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
